// File: rtl/fsqrt_pkg.sv
// Shared types and constants for the single-precision square-root issue stage.
package fsqrt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_INF,
    CLS_NAN,
    CLS_NORM
  } op_class_e;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  localparam logic [31:0] QNAN  = 32'h7fc0_0000;
  localparam logic [31:0] PINF  = 32'h7f80_0000;
  localparam int          BIAS  = 127;
  localparam int          EXP_W = 9;

  // Denormals have exp==0 and fold into the zero class.
  function automatic op_class_e classify(input fp32_t a);
    if (a.exp == 8'h00) return CLS_ZERO;
    if (a.exp == 8'hff) return (a.frac == '0) ? CLS_INF : CLS_NAN;
    return CLS_NORM;
  endfunction

  // Root exponent: halve the unbiased exponent, folding the odd case into the radicand shift.
  function automatic logic [EXP_W-1:0] root_exp(input logic [7:0] e);
    logic [EXP_W-1:0] sum;
    sum = {1'b0, e} + EXP_W'(BIAS - 1) + {{(EXP_W-1){1'b0}}, e[0]};
    return sum >> 1;
  endfunction

endpackage

// File: rtl/fsqrt_pack.sv
// Rounds the core's .1xxx root fraction half-up and packs it with the result exponent.
module fsqrt_pack
  import fsqrt_pkg::*;
(
  input  logic [31:0]      core_q,
  input  logic [EXP_W-1:0] res_exp,
  output logic [31:0]      out_r
);

  logic [23:0]      mant_sum;
  logic [22:0]      mant;
  logic [EXP_W-1:0] exp_adj;
  logic             unused_bits;

  // core_q[31] is the implied leading one; exponent never exceeds 8 bits after adjust.
  assign unused_bits = core_q[31] ^ exp_adj[EXP_W-1];

  always_comb begin
    mant_sum = {1'b0, core_q[30:8]} + {23'b0, core_q[7]};
    if (mant_sum[23]) begin
      mant    = '0;
      exp_adj = res_exp + EXP_W'(1);
    end else begin
      mant    = mant_sum[22:0];
      exp_adj = res_exp;
    end
    out_r = {1'b0, exp_adj[7:0], mant};
  end

endmodule

// File: rtl/fsqrt_issue.sv
// Issue/pack front end for an external square-root core: classifies the operand,
// bypasses special values and formats the core's root fraction as an IEEE single.
module fsqrt_issue
  import fsqrt_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [31:0] in_a,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_r,
  output logic        out_invalid,
  output logic [31:0] core_d,
  output logic        core_start,
  input  logic        core_busy,
  input  logic        core_ready,
  input  logic [31:0] core_q
);

  state_e           state_q,       state_d;
  logic             in_ready_q,    in_ready_d;
  logic             out_valid_q,   out_valid_d;
  logic [31:0]      out_r_q,       out_r_d;
  logic             out_invalid_q, out_invalid_d;
  logic             core_start_q,  core_start_d;
  logic [31:0]      core_d_q,      core_d_d;
  logic [EXP_W-1:0] res_exp_q,     res_exp_d;

  fp32_t       op;
  op_class_e   op_cls;
  logic [31:0] pack_r;

  assign op     = in_a;
  assign op_cls = classify(op);

  fsqrt_pack u_pack (
    .core_q  (core_q),
    .res_exp (res_exp_q),
    .out_r   (pack_r)
  );

  always_comb begin
    // NOTE: every _d gets a hold/default value first so no path through the case infers a latch.
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_r_d       = out_r_q;
    out_invalid_d = out_invalid_q;
    core_start_d  = 1'b0;
    core_d_d      = core_d_q;
    res_exp_d     = res_exp_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          in_ready_d    = 1'b0;
          out_valid_d   = 1'b1;
          out_invalid_d = 1'b0;
          state_d       = DONE;
          unique case (op_cls)
            CLS_ZERO: out_r_d = {op.sign, 31'b0};
            CLS_NAN: begin
              out_r_d       = QNAN;
              out_invalid_d = ~op.frac[22];
            end
            CLS_INF: begin
              out_r_d       = op.sign ? QNAN : PINF;
              out_invalid_d = op.sign;
            end
            CLS_NORM: begin
              if (op.sign) begin
                out_r_d       = QNAN;
                out_invalid_d = 1'b1;
              end else begin
                out_valid_d = 1'b0;
                state_d     = ISSUE;
                res_exp_d   = root_exp(op.exp);
                // Odd exponents shift one more place so the exponent halves exactly.
                core_d_d    = op.exp[0] ? {2'b01, op.frac, 7'b0} : {1'b1, op.frac, 8'b0};
              end
            end
            default: state_d = IDLE;
          endcase
        end
      end

      ISSUE: begin
        if (!core_busy) begin
          core_start_d = 1'b1;
          state_d      = WAIT;
        end
      end

      WAIT: begin
        if (core_ready) begin
          out_r_d       = pack_r;
          out_invalid_d = 1'b0;
          out_valid_d   = 1'b1;
          state_d       = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset clears every flop here, data included; there is no storage array to leave unreset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      out_r_q       <= '0;
      out_invalid_q <= 1'b0;
      core_start_q  <= 1'b0;
      core_d_q      <= '0;
      res_exp_q     <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_r_q       <= out_r_d;
      out_invalid_q <= out_invalid_d;
      core_start_q  <= core_start_d;
      core_d_q      <= core_d_d;
      res_exp_q     <= res_exp_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_r       = out_r_q;
  assign out_invalid = out_invalid_q;
  assign core_start  = core_start_q;
  assign core_d      = core_d_q;

endmodule

// File: tb/tb_fsqrt_issue.sv
// Scoreboard bench for fsqrt_issue with a behavioural square-root core model.
module tb_fsqrt_issue;

  localparam logic [31:0] TB_QNAN = 32'h7fc0_0000;
  localparam logic [31:0] TB_PINF = 32'h7f80_0000;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [31:0] in_a;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        out_invalid;
  logic [31:0] core_d;
  logic        core_start;
  logic        core_busy;
  logic        core_ready;
  logic [31:0] core_q;

  fsqrt_issue dut (
    .clock       (clock),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_a        (in_a),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_r       (out_r),
    .out_invalid (out_invalid),
    .core_d      (core_d),
    .core_start  (core_start),
    .core_busy   (core_busy),
    .core_ready  (core_ready),
    .core_q      (core_q)
  );

  always #5 clock = ~clock;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] sb_q[$];     // {invalid, result}
  logic [31:0] cd_q[$];     // expected core_d per core request
  logic [31:0] resp_q[$];   // root the core model returns
  int          n_starts = 0;
  int          n_resp = 0;
  int          starts0 = 0;
  int          exp_starts = 0;
  int          core_lat = 2;
  int          ready_mode = 2;  // 0 random, 1 held low, 2 held high
  bit          abort_flag = 1'b0;
  logic [31:0] last_r = '0;
  logic        last_inv = 1'b0;
  bit          hold_v = 1'b0;
  logic [32:0] hold_r = '0;
  bit          chk_ir = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s", msg);
  endtask

  // Integer square root of a 64-bit value, bit by bit from the top.
  function automatic logic [31:0] isqrt64(input logic [63:0] n);
    logic [31:0] q;
    logic [63:0] t;
    q = '0;
    for (int b = 31; b >= 0; b--) begin
      t = {32'b0, q | (32'h1 << b)};
      if (t * t <= n) q = q | (32'h1 << b);
    end
    return q;
  endfunction

  // sqrt(2^ue * 1.f) = 2^((ue+s)/2 - 1) * 2*sqrt(1.f / 2^s), s = 1 for odd ue, 2 for even ue.
  function automatic void ref_model(input logic [31:0] a, output bit byp, output logic [32:0] res,
                                    output logic [31:0] cd, output int rexp);
    bit     s;
    int     e, f, ue;
    longint sig;
    s = a[31];
    e = int'(a[30:23]);
    f = int'(a[22:0]);
    byp = 1'b1;
    cd = '0;
    rexp = 0;
    res = '0;
    if (e == 0)                  res = {1'b0, s, 31'b0};
    else if (e == 255 && f != 0) res = {~a[22], TB_QNAN};
    else if (s)                  res = {1'b1, TB_QNAN};
    else if (e == 255)           res = {1'b0, TB_PINF};
    else begin
      byp = 1'b0;
      ue  = e - 127;
      sig = longint'(f) + 64'h80_0000;
      if (ue % 2 != 0) begin
        cd   = 32'(sig * 256);
        rexp = (ue + 1) / 2 - 1 + 127;
      end else begin
        cd   = 32'(sig * 128);
        rexp = (ue + 2) / 2 - 1 + 127;
      end
    end
  endfunction

  function automatic logic [31:0] pack_ref(input logic [31:0] q, input int rexp);
    longint sig;
    int     ex;
    sig = (longint'({32'b0, q}) + 128) / 256;
    ex  = rexp;
    if (sig >= 64'h100_0000) begin
      sig = sig / 2;
      ex  = ex + 1;
    end
    return {1'b0, 8'(ex), sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    logic [7:0]  e;
    int          k;
    r = $urandom;
    e = 8'($urandom_range(1, 254));
    k = $urandom_range(0, 9);
    case (k)
      0:       return {r[31], 8'h00, r[22:0] & {23{r[23]}}};
      1:       return {r[31], 8'hff, 23'b0};
      2:       return {1'b0, 8'hff, 1'b1, r[21:0]};
      3:       return {r[31], 8'hff, 1'b0, r[21:1], 1'b1};
      4:       return {1'b1, e, r[22:0]};
      default: return {1'b0, e, r[22:0]};
    endcase
  endfunction

  // Downstream ready generator.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clock) begin
    if (resetn && core_start) n_starts++;
  end

  // Square-root core model: answers each start after core_lat cycles.
  initial begin
    core_ready = 1'b0;
    core_q     = '0;
    forever begin
      @(negedge clock);
      if (resetn && core_start) begin
        if (cd_q.size() == 0 || resp_q.size() == 0) begin
          fail_evt("core_start: got an unrequested start, required none");
        end else begin
          logic [31:0] rq;
          int          lat;
          check("core_d", core_d, cd_q.pop_front());
          rq  = resp_q.pop_front();
          lat = core_lat;
          repeat (lat) @(posedge clock);
          #1;
          core_q     = rq;
          core_ready = 1'b1;
          @(posedge clock);
          #1;
          core_ready = 1'b0;
          core_q     = $urandom;
          @(negedge clock);
          check(abort_flag ? "late_core_ready_ignored" : "core_ready_to_out_valid",
                out_valid, abort_flag ? 1'b0 : 1'b1);
          n_resp++;
        end
      end
    end
  end

  // Output monitor and scoreboard.
  always @(negedge clock) begin
    if (!resetn) begin
      hold_v = 1'b0;
      chk_ir = 1'b0;
    end else begin
      if (chk_ir) begin
        check("in_ready_after_handshake", in_ready, 1'b1);
        chk_ir = 1'b0;
      end
      if (out_valid) begin
        check("in_ready_low_while_valid", in_ready, 1'b0);
        if (hold_v) check("out_held_under_backpressure", {out_invalid, out_r}, hold_r);
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            fail_evt("out_handshake: got an unexpected result, required none");
          end else begin
            logic [32:0] e;
            e = sb_q.pop_front();
            check("out_r", out_r, e[31:0]);
            check("out_invalid", out_invalid, e[32]);
            last_r   = out_r;
            last_inv = out_invalid;
          end
          hold_v = 1'b0;
          chk_ir = 1'b1;
        end else begin
          hold_v = 1'b1;
          hold_r = {out_invalid, out_r};
        end
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  task automatic flush();
    sb_q.delete();
    cd_q.delete();
    resp_q.delete();
  endtask

  task automatic issue(input logic [31:0] a, input int busy_cycles, input bit ovr_en,
                       input logic [31:0] ovr_q);
    bit          byp;
    logic [32:0] res;
    logic [31:0] cd, q;
    int          rexp, cnt;
    ref_model(a, byp, res, cd, rexp);
    if (!byp) begin
      q   = ovr_en ? ovr_q : isqrt64({cd, 32'b0});
      res = {1'b0, pack_ref(q, rexp)};
      cd_q.push_back(cd);
      resp_q.push_back(q);
    end
    sb_q.push_back(res);
    starts0    = n_starts;
    exp_starts = byp ? 0 : 1;
    @(posedge clock);
    #1;
    in_valid  = 1'b1;
    in_a      = a;
    core_busy = (busy_cycles > 0);
    cnt = 0;
    @(negedge clock);
    while (!in_ready && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    if (!in_ready) begin
      fail_evt("accept: got in_ready=0 for 100 cycles, required 1");
      in_valid  = 1'b0;
      core_busy = 1'b0;
      flush();
      return;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    if (byp) core_busy = 1'b0;
    @(negedge clock);
    if (byp) begin
      check("bypass_latency_out_valid", out_valid, 1'b1);
      check("bypass_core_start", core_start, 1'b0);
    end else if (busy_cycles > 0) begin
      for (int i = 0; i < busy_cycles; i++) begin
        check("start_while_busy", core_start, 1'b0);
        @(posedge clock);
        #1;
        if (i == busy_cycles - 1) core_busy = 1'b0;
        @(negedge clock);
      end
      @(negedge clock);
      check("start_after_busy_drops", core_start, 1'b1);
    end
  endtask

  task automatic wait_done();
    int cnt;
    cnt = 0;
    while (sb_q.size() != 0 && cnt < 400) begin
      @(negedge clock);
      cnt++;
    end
    if (sb_q.size() != 0) begin
      fail_evt("done: got no result in 400 cycles, required one");
      flush();
    end
    check("core_start_cycles", 64'(n_starts - starts0), 64'(exp_starts));
  endtask

  task automatic run(input logic [31:0] a, input int busy_cycles, input bit ovr_en,
                     input logic [31:0] ovr_q);
    issue(a, busy_cycles, ovr_en, ovr_q);
    wait_done();
  endtask

  initial begin
    int cnt, resp0;
    resetn    = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    core_busy = 1'b0;
    #2 resetn = 1'b0;
    #2;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_r", out_r, 32'h0);
    check("reset_out_invalid", out_invalid, 1'b0);
    check("reset_core_start", core_start, 1'b0);
    check("reset_core_d", core_d, 32'h0);
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    ready_mode = 2;
    core_lat   = 2;
    run(32'h4080_0000, 0, 1'b0, 32'h0);
    check("lit_sqrt4_r", last_r, 32'h4000_0000);
    check("lit_sqrt4_inv", last_inv, 1'b0);
    run(32'h4000_0000, 0, 1'b1, 32'hb504_f334);
    check("lit_sqrt2_r", last_r, 32'h3fb5_04f3);
    run(32'hbf80_0000, 0, 1'b0, 32'h0);
    check("lit_neg1_r", last_r, 32'h7fc0_0000);
    check("lit_neg1_inv", last_inv, 1'b1);
    run(32'h7f80_0000, 0, 1'b0, 32'h0);
    check("lit_pinf_r", last_r, 32'h7f80_0000);
    check("lit_pinf_inv", last_inv, 1'b0);
    run(32'h8000_0000, 0, 1'b0, 32'h0);
    check("lit_negzero_r", last_r, 32'h8000_0000);
    check("lit_negzero_inv", last_inv, 1'b0);
    run(32'h3f80_0000, 3, 1'b0, 32'h0);
    check("lit_busy_one_r", last_r, 32'h3f80_0000);
    run(32'h3f80_0000, 0, 1'b1, 32'hffff_ff80);
    check("lit_round_carry_r", last_r, 32'h4000_0000);
    run(32'h3f80_0000, 0, 1'b1, 32'hffff_ff7f);
    check("lit_round_nocarry_r", last_r, 32'h3fff_ffff);
    run(32'h7f80_0001, 0, 1'b0, 32'h0);
    check("lit_snan_inv", last_inv, 1'b1);
    run(32'h7fc0_0001, 0, 1'b0, 32'h0);
    check("lit_qnan_inv", last_inv, 1'b0);
    run(32'h807f_ffff, 0, 1'b0, 32'h0);
    check("lit_neg_denormal_r", last_r, 32'h8000_0000);
    run(32'hff80_0000, 0, 1'b0, 32'h0);
    check("lit_neginf_inv", last_inv, 1'b1);

    // Backpressure: result held for five cycles with out_ready low.
    ready_mode = 1;
    issue(32'h3f80_0000, 0, 1'b0, 32'h0);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(negedge clock);
      cnt++;
    end
    check("stall_out_valid_seen", out_valid, 1'b1);
    check("stall_out_r", out_r, 32'h3f80_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_out_r_stable", out_r, 32'h3f80_0000);
      check("stall_in_ready_low", in_ready, 1'b0);
    end
    ready_mode = 2;
    wait_done();

    // Reset while the core is working; its late answer must be ignored.
    core_lat   = 8;
    abort_flag = 1'b1;
    resp0      = n_resp;
    issue(32'h4000_0000, 0, 1'b0, 32'h0);
    cnt = 0;
    while (n_starts == starts0 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    check("abort_core_started", 64'(n_starts - starts0), 64'd1);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_out_r", out_r, 32'h0);
    check("abort_core_start", core_start, 1'b0);
    check("abort_core_d", core_d, 32'h0);
    flush();
    @(posedge clock);
    #1 resetn = 1'b1;
    cnt = 0;
    while (n_resp == resp0 && cnt < 50) begin
      @(negedge clock);
      cnt++;
    end
    check("abort_late_ready_delivered", 64'(n_resp - resp0), 64'd1);
    @(negedge clock);
    check("abort_idle_out_valid", out_valid, 1'b0);
    check("abort_idle_in_ready", in_ready, 1'b1);
    abort_flag = 1'b0;

    // Randomized traffic with backpressure, core latency and busy holds.
    ready_mode = 0;
    for (int t = 0; t < 40; t++) begin
      logic [31:0] rq;
      bit          ovr;
      core_lat = $urandom_range(1, 5);
      rq       = {1'b1, 31'($urandom)};
      ovr      = ($urandom_range(0, 7) == 0);
      run(rand_operand(), $urandom_range(0, 2), ovr, rq);
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion by 400000 time units, required completion");
    n_tests++;
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
